// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, instruction constants and fetch-address check.
package fetch_pkg;
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } state_t;
  localparam logic [31:0] NOP_INST    = 32'h0000_0013;
  localparam logic [31:0] ECALL_INST  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
  function automatic logic pc_ok(input logic [31:0] pc, input int unsigned aw);
    return (pc[1:0] == 2'b00) && ((pc >> (aw + 2)) == 32'h0);
  endfunction
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load, hold and bubble controls.
module if_id_reg #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_bubble,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc4
);
  logic        r_valid;
  logic [31:0] r_inst;
  logic [31:0] r_pc;
  logic [31:0] r_pc4;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_inst  <= NOP_INST;
      r_pc    <= 32'h0;
      r_pc4   <= 32'h0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_inst  <= i_inst;
      r_pc    <= i_pc;
      r_pc4   <= i_pc + 32'd4;
    end else if (i_bubble) begin
      r_valid <= 1'b0;
      r_inst  <= NOP_INST;
    end
  end
  assign o_valid = r_valid;
  assign o_inst  = r_inst;
  assign o_pc    = r_pc;
  assign o_pc4   = r_pc4;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, fetch FSM and fetch counter feeding the IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned IMEM_ADDR_W = 6,
  parameter logic [31:0] NOP_INST    = fetch_pkg::NOP_INST
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_data,
  output logic                   if_id_valid,
  output logic [31:0]            if_id_inst,
  output logic [31:0]            if_id_pc,
  output logic [31:0]            if_id_pc4,
  output logic [31:0]            pc,
  output logic                   halted,
  output logic                   fault,
  output logic [31:0]            fetch_count
);
  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] w_next_pc;
  logic [31:0] r_fetch_count;
  logic        w_load;
  logic        w_bubble;
  logic        w_pc_ok;
  logic        w_sys;
  assign w_pc_ok = pc_ok(r_pc, IMEM_ADDR_W);
  assign w_sys   = (imem_data == ECALL_INST) || (imem_data == EBREAK_INST);
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_load       = 1'b0;
    w_bubble     = 1'b0;
    if (redirect && r_state != FAULT) begin
      w_next_pc    = redirect_pc;
      w_bubble     = 1'b1;
      w_next_state = RUN;
    end else if (!stall) begin
      if (r_state == RUN && w_pc_ok) begin
        w_load       = 1'b1;
        w_next_pc    = w_sys ? r_pc : r_pc + 32'd4;
        w_next_state = w_sys ? HALT : RUN;
      end else begin
        w_bubble     = 1'b1;
        w_next_state = (r_state == RUN) ? FAULT : r_state;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_pc          <= RESET_PC;
      r_fetch_count <= 32'h0;
    end else begin
      r_state       <= w_next_state;
      r_pc          <= w_next_pc;
      r_fetch_count <= r_fetch_count + {31'h0, w_load};
    end
  end
  if_id_reg #(.NOP_INST(NOP_INST)) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_bubble (w_bubble),
    .i_inst   (imem_data),
    .i_pc     (r_pc),
    .o_valid  (if_id_valid),
    .o_inst   (if_id_inst),
    .o_pc     (if_id_pc),
    .o_pc4    (if_id_pc4)
  );
  assign imem_addr   = r_pc[IMEM_ADDR_W+1:2];
  assign pc          = r_pc;
  assign halted      = (r_state == HALT);
  assign fault       = (r_state == FAULT);
  assign fetch_count = r_fetch_count;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios against fetch_stage with a 64-word combinational memory.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic        if_id_valid;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] pc;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;
  logic [31:0] mem [64];
  int total = 0;
  int bad = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_data(imem_data), .if_id_valid(if_id_valid),
    .if_id_inst(if_id_inst), .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4), .pc(pc),
    .halted(halted), .fault(fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=%h", pc, 32'h0); end
    total++; if (if_id_inst !== 32'h13) begin bad++; $display("FAIL rst_inst got=%h exp=%h", if_id_inst, 32'h13); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", if_id_valid); end
    total++; if (if_id_pc !== 32'h0 || if_id_pc4 !== 32'h0) begin bad++; $display("FAIL rst_ifid_pc got=%h/%h exp=0/0", if_id_pc, if_id_pc4); end
    total++; if (fetch_count !== 32'h0 || halted !== 1'b0 || fault !== 1'b0) begin bad++; $display("FAIL rst_status got cnt=%h h=%b f=%b exp=0/0/0", fetch_count, halted, fault); end
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    total++; if (imem_addr !== 6'd0) begin bad++; $display("FAIL run_addr0 got=%h exp=0", imem_addr); end
    step();
    total++; if (if_id_pc !== 32'h0 || if_id_inst !== 32'h83 || if_id_valid !== 1'b1) begin bad++; $display("FAIL run_e1 got pc=%h inst=%h v=%b exp 0/83/1", if_id_pc, if_id_inst, if_id_valid); end
    total++; if (pc !== 32'h4 || imem_addr !== 6'd1) begin bad++; $display("FAIL run_e1_pc got=%h addr=%h exp=4/1", pc, imem_addr); end
    step();
    total++; if (if_id_pc !== 32'h4 || if_id_pc4 !== 32'h8 || if_id_inst !== 32'h103) begin bad++; $display("FAIL run_e2 got pc=%h pc4=%h inst=%h exp 4/8/103", if_id_pc, if_id_pc4, if_id_inst); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (pc !== 32'h8 || if_id_inst !== 32'h103 || fetch_count !== 32'd2) begin bad++; $display("FAIL stall_hold%0d got pc=%h inst=%h cnt=%0d exp 8/103/2", i, pc, if_id_inst, fetch_count); end
    end
    stall = 1'b0;
    step();
    total++; if (if_id_pc !== 32'h8 || if_id_inst !== 32'h00100093 || fetch_count !== 32'd3 || pc !== 32'hC) begin bad++; $display("FAIL stall_release got pc=%h inst=%h cnt=%0d fpc=%h exp 8/00100093/3/c", if_id_pc, if_id_inst, fetch_count, pc); end
  endtask

  task automatic test_redirect();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h20;
    step();
    stall = 1'b0; redirect = 1'b0;
    total++; if (pc !== 32'h20 || if_id_inst !== 32'h13 || if_id_valid !== 1'b0 || fetch_count !== 32'd3) begin bad++; $display("FAIL redir got pc=%h inst=%h v=%b cnt=%0d exp 20/13/0/3", pc, if_id_inst, if_id_valid, fetch_count); end
    step();
    total++; if (if_id_pc !== 32'h20 || if_id_valid !== 1'b1 || pc !== 32'h24 || fetch_count !== 32'd4) begin bad++; $display("FAIL redir_next got pc=%h v=%b fpc=%h cnt=%0d exp 20/1/24/4", if_id_pc, if_id_valid, pc, fetch_count); end
  endtask

  task automatic test_ecall();
    redirect = 1'b1; redirect_pc = 32'h14;
    step();
    redirect = 1'b0;
    step();
    total++; if (if_id_inst !== 32'h73 || if_id_valid !== 1'b1 || halted !== 1'b1 || pc !== 32'h14 || fetch_count !== 32'd5) begin bad++; $display("FAIL ecall got inst=%h v=%b h=%b pc=%h cnt=%0d exp 73/1/1/14/5", if_id_inst, if_id_valid, halted, pc, fetch_count); end
    step();
    total++; if (if_id_valid !== 1'b0 || if_id_inst !== 32'h13 || pc !== 32'h14 || halted !== 1'b1 || fetch_count !== 32'd5) begin bad++; $display("FAIL halt_hold got v=%b inst=%h pc=%h h=%b cnt=%0d exp 0/13/14/1/5", if_id_valid, if_id_inst, pc, halted, fetch_count); end
    redirect = 1'b1; redirect_pc = 32'h0;
    step();
    redirect = 1'b0;
    total++; if (halted !== 1'b0 || pc !== 32'h0 || if_id_valid !== 1'b0) begin bad++; $display("FAIL halt_resume got h=%b pc=%h v=%b exp 0/0/0", halted, pc, if_id_valid); end
    step();
    total++; if (if_id_inst !== 32'h83 || if_id_valid !== 1'b1 || pc !== 32'h4) begin bad++; $display("FAIL resume_fetch got inst=%h v=%b pc=%h exp 83/1/4", if_id_inst, if_id_valid, pc); end
  endtask

  task automatic test_bad_redirect();
    redirect = 1'b1; redirect_pc = 32'h102;
    step();
    redirect = 1'b0;
    total++; if (pc !== 32'h102 || fault !== 1'b0) begin bad++; $display("FAIL badredir_load got pc=%h f=%b exp 102/0", pc, fault); end
    step();
    total++; if (fault !== 1'b1 || if_id_valid !== 1'b0 || pc !== 32'h102) begin bad++; $display("FAIL badredir_fault got f=%b v=%b pc=%h exp 1/0/102", fault, if_id_valid, pc); end
    redirect = 1'b1; redirect_pc = 32'h0;
    step();
    redirect = 1'b0;
    total++; if (fault !== 1'b1 || pc !== 32'h102 || if_id_valid !== 1'b0) begin bad++; $display("FAIL fault_ignore got f=%b pc=%h v=%b exp 1/102/0", fault, pc, if_id_valid); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (fault !== 1'b0 || pc !== 32'h0 || fetch_count !== 32'h0) begin bad++; $display("FAIL fault_rst got f=%b pc=%h cnt=%0d exp 0/0/0", fault, pc, fetch_count); end
  endtask

  task automatic test_last_word();
    redirect = 1'b1; redirect_pc = 32'hFC;
    step();
    redirect = 1'b0;
    total++; if (imem_addr !== 6'd63) begin bad++; $display("FAIL last_addr got=%h exp=3f", imem_addr); end
    step();
    total++; if (if_id_inst !== 32'h00A00093 || if_id_pc !== 32'hFC || if_id_pc4 !== 32'h100 || pc !== 32'h100 || if_id_valid !== 1'b1) begin bad++; $display("FAIL last_fetch got inst=%h ipc=%h pc4=%h pc=%h v=%b exp 00a00093/fc/100/100/1", if_id_inst, if_id_pc, if_id_pc4, pc, if_id_valid); end
    step();
    total++; if (fault !== 1'b1 || if_id_valid !== 1'b0 || pc !== 32'h100) begin bad++; $display("FAIL overrun_fault got f=%b v=%b pc=%h exp 1/0/100", fault, if_id_valid, pc); end
  endtask

  task automatic test_rst_in_halt();
    rst = 1'b1;
    step();
    rst = 1'b0; redirect = 1'b1; redirect_pc = 32'h14;
    step();
    redirect = 1'b0;
    step();
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL pre_rst_halt got h=%b exp 1", halted); end
    rst = 1'b1; stall = 1'b1;
    step();
    rst = 1'b0; stall = 1'b0;
    total++; if (pc !== 32'h0 || halted !== 1'b0 || fault !== 1'b0 || fetch_count !== 32'h0 || if_id_valid !== 1'b0 || if_id_inst !== 32'h13 || if_id_pc !== 32'h0 || if_id_pc4 !== 32'h0) begin bad++; $display("FAIL rst_halt got pc=%h h=%b f=%b cnt=%0d v=%b inst=%h ipc=%h pc4=%h exp all reset", pc, halted, fault, fetch_count, if_id_valid, if_id_inst, if_id_pc, if_id_pc4); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
    mem[0]  = 32'h0000_0083;
    mem[1]  = 32'h0000_0103;
    mem[2]  = 32'h0010_0093;
    mem[5]  = 32'h0000_0073;
    mem[63] = 32'h00A0_0093;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_ecall();
    test_bad_redirect();
    test_last_word();
    test_rst_in_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
